// File: rtl/led_seq_pkg.sv
// rtl/led_seq_pkg.sv - shared types and constants for the LED pattern sequencer
//
// Purpose : mode/phase encodings, default geometry and a small width helper
// Ports   : none (package)
package led_seq_pkg;

   typedef enum logic [1:0] {
      AUTO   = 2'd0,
      BLINK  = 2'd1,
      CHASE  = 2'd2,
      BOUNCE = 2'd3
   } mode_e;

   typedef enum logic [1:0] {
      PH_BLINK = 2'd0,
      PH_SHR   = 2'd1,
      PH_SHL   = 2'd2
   } phase_e;

   localparam int DEF_WIDTH       = 8;
   localparam int DEF_BLINK_STEPS = 6;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/step_tick_gen.sv
// rtl/step_tick_gen.sv - step prescaler producing one tick every div+1 enabled cycles
//
// Purpose : counts enabled clkout cycles and flags the cycle on which a step happens
// Ports   : clkout  - step clock
//           rst     - asynchronous active-high reset
//           en      - 1 = count, 0 = hold count and suppress tick
//           div     - step period minus one
//           tick    - combinational, high on the cycle whose edge performs a step
module step_tick_gen #(
   parameter int DIV_W = 4
) (
   input  logic             clkout,
   input  logic             rst,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tick
);

   logic [DIV_W-1:0] pcnt_q;
   logic [DIV_W-1:0] pcnt_d;

   // >= rather than == so that lowering div below the current count fires
   // on the next cycle instead of wrapping through the whole counter range.
   assign tick = en && (pcnt_q >= div);

   always_comb begin
      pcnt_d = pcnt_q;
      if (en) begin
         pcnt_d = tick ? '0 : pcnt_q + 1'b1;
      end
   end

   always_ff @(posedge clkout or posedge rst) begin
      if (rst) begin
         pcnt_q <= '0;
      end else begin
         pcnt_q <= pcnt_d;
      end
   end

endmodule

// File: rtl/led_pattern_seq.sv
// rtl/led_pattern_seq.sv - LED light-show sequencer (auto / blink / chase / bounce)
//
// Purpose : steps an LED pattern once per prescaler tick, with run/pause and status pulses
// Ports   : clkout     - step clock from the clock divider
//           rst        - asynchronous active-high reset
//           en         - 1 = run, 0 = pause (all state frozen)
//           mode       - 0 auto, 1 blink, 2 chase right, 3 bounce
//           div        - one step every div+1 enabled cycles
//           LED        - registered LED drive
//           phase      - auto phase (0 BLINK, 1 SHR, 2 SHL), 0 in other modes
//           step_done  - pulse coincident with each LED update
//           cycle_done - pulse on the last step of a full auto cycle
module led_pattern_seq
   import led_seq_pkg::*;
#(
   parameter int WIDTH       = DEF_WIDTH,
   parameter int BLINK_STEPS = DEF_BLINK_STEPS,
   parameter int DIV_W       = 4
) (
   input  logic             clkout,
   input  logic             rst,
   input  logic             en,
   input  logic [1:0]       mode,
   input  logic [DIV_W-1:0] div,
   output logic [WIDTH-1:0] LED,
   output logic [1:0]       phase,
   output logic             step_done,
   output logic             cycle_done
);

   localparam int CNT_W = $clog2(max_int(BLINK_STEPS, WIDTH)) + 1;
   localparam logic [CNT_W-1:0] BLINK_LAST = CNT_W'(BLINK_STEPS - 1);
   localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MSB_ONLY   = {1'b1, {(WIDTH-1){1'b0}}};

   logic             tick;
   mode_e            mode_in;

   logic [WIDTH-1:0] led_q, led_d;
   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   mode_e            mode_q, mode_d;
   logic             dir_q, dir_d;        // 0 = moving right, 1 = moving left
   logic             step_done_q;
   logic             cycle_done_q, cyc_d;
   logic [WIDTH-1:0] bounce_nxt;

   step_tick_gen #(.DIV_W(DIV_W)) u_tick (
      .clkout (clkout),
      .rst    (rst),
      .en     (en),
      .div    (div),
      .tick   (tick)
   );

   assign mode_in    = mode_e'(mode);
   assign bounce_nxt = dir_q ? (led_q << 1) : (led_q >> 1);

   always_comb begin
      led_d   = led_q;
      phase_d = phase_q;
      cnt_d   = cnt_q;
      mode_d  = mode_q;
      dir_d   = dir_q;
      cyc_d   = 1'b0;

      if (mode_in != mode_q) begin
         // Entry step of the new mode; any progress in the old mode is dropped.
         mode_d  = mode_in;
         phase_d = PH_BLINK;
         cnt_d   = '0;
         dir_d   = 1'b0;
         case (mode_in)
            AUTO: begin
               // The entry step counts as the first blink step.
               led_d = '1;
               if (BLINK_STEPS == 1) begin
                  phase_d = PH_SHR;
               end else begin
                  cnt_d = CNT_W'(1);
               end
            end
            BLINK:   led_d = '1;
            default: led_d = MSB_ONLY;
         endcase
      end else begin
         case (mode_q)
            AUTO: begin
               case (phase_q)
                  PH_BLINK: begin
                     led_d = ~led_q;
                     if (cnt_q == BLINK_LAST) begin
                        phase_d = PH_SHR;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  PH_SHR: begin
                     led_d = (cnt_q == '0) ? MSB_ONLY : (led_q >> 1);
                     if (cnt_q == SHIFT_LAST) begin
                        phase_d = PH_SHL;
                        cnt_d   = '0;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  PH_SHL: begin
                     led_d = led_q << 1;
                     if (cnt_q == SHIFT_LAST) begin
                        phase_d = PH_BLINK;
                        cnt_d   = '0;
                        cyc_d   = 1'b1;
                     end else begin
                        cnt_d = cnt_q + 1'b1;
                     end
                  end
                  default: begin
                     phase_d = PH_BLINK;
                     cnt_d   = '0;
                  end
               endcase
            end
            BLINK: led_d = ~led_q;
            CHASE: led_d = {led_q[0], led_q[WIDTH-1:1]};
            default: begin
               led_d = bounce_nxt;
               // Turn around on the step that lands on an end, so each end shows once.
               if (bounce_nxt[0]) begin
                  dir_d = 1'b1;
               end else if (bounce_nxt[WIDTH-1]) begin
                  dir_d = 1'b0;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clkout or posedge rst) begin
      if (rst) begin
         led_q        <= '0;
         phase_q      <= PH_BLINK;
         cnt_q        <= '0;
         mode_q       <= AUTO;
         dir_q        <= 1'b0;
         step_done_q  <= 1'b0;
         cycle_done_q <= 1'b0;
      end else begin
         step_done_q  <= tick;
         cycle_done_q <= tick & cyc_d;
         if (tick) begin
            led_q   <= led_d;
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            dir_q   <= dir_d;
         end
      end
   end

   assign LED        = led_q;
   assign phase      = phase_q;
   assign step_done  = step_done_q;
   assign cycle_done = cycle_done_q;

endmodule
